// File: rtl/freq_meter.sv
// freq_meter: gated edge-counting frequency meter.
// Counts rising edges of an asynchronous pulse input over a fixed window of
// GATE clk_in cycles and publishes the result with a one-cycle valid strobe.
// Windows run back to back while en stays high; dropping en discards the
// window in progress.
module freq_meter #(
   parameter int GATE   = 1000,
   parameter int GATE_W = 10,
   parameter int WIDTH  = 16
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [WIDTH-1:0] count,
   output logic             valid,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GATE = 1'b1
   } state_t;

   // Last value of the window counter inside a window.
   localparam logic [GATE_W-1:0] GCNT_LAST = GATE_W'(GATE - 1);
   // Saturation value of the edge counter.
   localparam logic [WIDTH-1:0]  ECNT_MAX  = {WIDTH{1'b1}};

   state_t              state;
   state_t              state_next;

   logic                s1;
   logic                s2;
   logic                s3;
   logic                rise;

   logic [GATE_W-1:0]   gcnt;
   logic [WIDTH-1:0]    ecnt;
   logic                osat;

   logic                ecnt_full;
   logic                last_cycle;
   logic                counting;

   // Two-flop synchronizer for sig_in plus one delay stage for edge detection.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise      = s2 & ~s3;
   assign ecnt_full = (ecnt == ECNT_MAX);

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and window-control decodes.
   // last_cycle: this edge closes a completed window.
   // counting:   this edge is inside a window that continues afterwards.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      last_cycle = 1'b0;
      counting   = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_next = S_GATE;
            end
         end
         S_GATE: begin
            busy = 1'b1;
            if (!en) begin
               // Abort: the partial window is thrown away.
               state_next = S_IDLE;
            end else if (gcnt == GCNT_LAST) begin
               // Window ends; the next one starts immediately.
               last_cycle = 1'b1;
            end else begin
               counting   = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Window counter: runs 0 .. GATE-1 inside a window, cleared otherwise.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         gcnt <= '0;
      end else if (counting) begin
         gcnt <= gcnt + GATE_W'(1);
      end else begin
         gcnt <= '0;
      end
   end

   // Saturating edge counter and its overflow flag for the open window.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ecnt <= '0;
         osat <= 1'b0;
      end else if (counting) begin
         if (rise) begin
            if (ecnt_full) begin
               osat <= 1'b1;
            end else begin
               ecnt <= ecnt + WIDTH'(1);
            end
         end
      end else begin
         ecnt <= '0;
         osat <= 1'b0;
      end
   end

   // Publish the result at the end of a window; a rise in the final cycle
   // still belongs to the window that is closing.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         ovf   <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= last_cycle;
         if (last_cycle) begin
            if (rise && ecnt_full) begin
               count <= ECNT_MAX;
               ovf   <= 1'b1;
            end else begin
               count <= ecnt + WIDTH'(rise);
               ovf   <= osat;
            end
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: three freq_meter instances with different window/width
// settings share one randomized stimulus; each is compared every cycle
// against a window-level reference model built from sampled input history.
module tb_freq_meter;

   localparam int NI   = 3;
   localparam int HMAX = 16384;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic        en     = 1'b0;
   logic        sig_in = 1'b0;

   logic [15:0] count_a;
   logic        valid_a, ovf_a, busy_a;
   logic [2:0]  count_b;
   logic        valid_b, ovf_b, busy_b;
   logic [7:0]  count_c;
   logic        valid_c, ovf_c, busy_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_in = ~clk_in;

   freq_meter #(.GATE(10), .GATE_W(4), .WIDTH(16)) dut_a (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .count(count_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a)
   );

   freq_meter #(.GATE(20), .GATE_W(5), .WIDTH(3)) dut_b (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .count(count_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b)
   );

   freq_meter #(.GATE(16), .GATE_W(4), .WIDTH(8)) dut_c (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .count(count_c), .valid(valid_c), .ovf(ovf_c), .busy(busy_c)
   );

   // ---------------- reference model ----------------
   int  gate_p  [NI];
   int  width_p [NI];
   bit  in_win  [NI];
   int  win_start [NI];
   int  exp_count [NI];
   bit  exp_ovf   [NI];
   bit  exp_valid [NI];
   int  n_valid   [NI];
   bit  samp [HMAX];
   int  edge_no = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, want, edge_no);
      end
   endtask

   // Rising edge seen by the meter at clock edge j: input high at edge j-2
   // after being low at edge j-3.
   function automatic int rise_at(input int j);
      if (j < 3) return 0;
      return (samp[j-2] && !samp[j-3]) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         in_win[i]    = 1'b0;
         exp_count[i] = 0;
         exp_ovf[i]   = 1'b0;
         exp_valid[i] = 1'b0;
      end
   endtask

   // Advance the model by one clock edge using the inputs sampled at it.
   task automatic model_edge();
      int raw;
      int maxv;
      samp[edge_no] = rst_n ? sig_in : 1'b0;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            in_win[i]    = 1'b0;
            exp_valid[i] = 1'b0;
            exp_count[i] = 0;
            exp_ovf[i]   = 1'b0;
         end else begin
            exp_valid[i] = 1'b0;
            if (!in_win[i]) begin
               if (en) begin
                  in_win[i]    = 1'b1;
                  win_start[i] = edge_no;
               end
            end else if (!en) begin
               in_win[i] = 1'b0;
            end else if (edge_no - win_start[i] == gate_p[i]) begin
               raw = 0;
               for (int j = win_start[i] + 1; j <= edge_no; j++) raw += rise_at(j);
               maxv = (1 << width_p[i]) - 1;
               exp_count[i] = (raw > maxv) ? maxv : raw;
               exp_ovf[i]   = (raw > maxv);
               exp_valid[i] = 1'b1;
               n_valid[i]++;
               win_start[i] = edge_no;
            end
         end
      end
      edge_no++;
   endtask

   task automatic cmp_inst(input int i, input string nm, input int unsigned c,
                           input bit v, input bit o, input bit b);
      check({nm, ".count"}, c, exp_count[i]);
      check({nm, ".valid"}, v, exp_valid[i]);
      check({nm, ".ovf"},   o, exp_ovf[i]);
      check({nm, ".busy"},  b, in_win[i]);
   endtask

   task automatic compare_all();
      cmp_inst(0, "A", count_a, valid_a, ovf_a, busy_a);
      cmp_inst(1, "B", count_b, valid_b, ovf_b, busy_b);
      cmp_inst(2, "C", count_c, valid_c, ovf_c, busy_c);
   endtask

   // One clock: model the edge, then sample outputs 1 time unit later.
   task automatic step();
      @(posedge clk_in);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Asynchronous reset in mid-cycle, held over several edges.
   task automatic async_reset(input bit sig_at_release);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      run(4);
      sig_in = sig_at_release;
      rst_n  = 1'b1;
   endtask

   initial begin
      gate_p  = '{10, 20, 16};
      width_p = '{16, 3, 8};
      for (int i = 0; i < NI; i++) n_valid[i] = 0;
      model_reset();

      // Reset state, then idle with en low.
      run(4);
      rst_n = 1'b1;
      run(6);
      $display("reset/idle: %0d checks so far", n_checks);

      // Nominal: maximum-rate input, en held high.
      en = 1'b1;
      for (int k = 0; k < 60; k++) begin
         sig_in = ~sig_in;
         step();
      end
      $display("nominal: valid A=%0d B=%0d C=%0d", n_valid[0], n_valid[1], n_valid[2]);

      // Quiet input: three windows of the longest gate with no edges.
      sig_in = 1'b0;
      run(3 * 20 + 4);
      $display("quiet: valid A=%0d B=%0d C=%0d", n_valid[0], n_valid[1], n_valid[2]);

      // Abort: drop en mid-window, then restart.
      for (int k = 0; k < 5; k++) begin
         sig_in = ~sig_in;
         step();
      end
      en = 1'b0;
      run(3);
      en = 1'b1;
      run(25);
      $display("abort/restart: %0d checks so far", n_checks);

      // Boundary: single rise landing in the final cycle of an A window.
      en = 1'b0;
      sig_in = 1'b0;
      run(3);
      en = 1'b1;
      step();            // window opens after this edge
      run(7);
      sig_in = 1'b1;
      step();            // sampled 8 edges after the opening edge
      sig_in = 1'b0;
      run(25);
      $display("boundary: last A count=%0d valid A=%0d", exp_count[0], n_valid[0]);

      // Asynchronous reset mid-window, input high at release, en low after.
      en = 1'b1;
      sig_in = 1'b1;
      run(7);
      async_reset(1'b1);
      en = 1'b0;
      run(8);
      en = 1'b1;
      run(30);
      $display("async reset: %0d checks so far", n_checks);

      // Randomized: random input levels, bursts of max rate, random aborts.
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         case ($urandom_range(0, 3))
            0:       sig_in = ~sig_in;
            1:       sig_in = 1'b0;
            default: sig_in = 1'($urandom_range(0, 1));
         endcase
         step();
         if (k == 1200) async_reset(1'($urandom_range(0, 1)));
      end
      $display("random: valid A=%0d B=%0d C=%0d", n_valid[0], n_valid[1], n_valid[2]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
